// File: rtl/crc_fsm.sv
// Scan controller for the CRC block: walks memory from a start address to 1023,
// qualifies each returned word with crc_en, and flags completion with crc_rdy.
module crc_fsm (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic       crc_start,
    input  logic [9:0] mem_addr_in,
    output logic [9:0] mem_addr_out,
    output logic       crc_en,
    output logic       crc_rdy
);

    localparam int unsigned ADDR_W = 10;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(1023);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic              en_nxt;
    logic              rdy_nxt;

    // State and registered outputs
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            crc_en  <= 1'b0;
            crc_rdy <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            crc_en  <= en_nxt;
            crc_rdy <= rdy_nxt;
        end
    end

    // Next state; crc_en is raised one cycle behind each address to match read latency
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        en_nxt    = 1'b0;
        rdy_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (crc_start) begin
                    addr_nxt  = mem_addr_in;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                en_nxt = 1'b1;
                if (addr == LAST_ADDR) begin
                    state_nxt = FLUSH;
                end else begin
                    addr_nxt = addr + ADDR_W'(1);
                end
            end
            FLUSH: begin
                rdy_nxt   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                rdy_nxt = 1'b1;
                // Start must drop for an edge before another scan can begin
                if (!crc_start) begin
                    rdy_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr_out = addr;

endmodule

// File: tb/tb_crc_fsm.sv
// Directed bench for crc_fsm: reset, short pulse, full/partial/one-word scans,
// restart, mid-scan start/address changes and mid-scan reset.
module tb_crc_fsm;

    logic       clk50m;
    logic       rst_n;
    logic       crc_start;
    logic [9:0] mem_addr_in;
    logic [9:0] mem_addr_out;
    logic       crc_en;
    logic       crc_rdy;

    int n_checks = 0;
    int n_pass   = 0;

    crc_fsm dut (
        .clk50m      (clk50m),
        .rst_n       (rst_n),
        .crc_start   (crc_start),
        .mem_addr_in (mem_addr_in),
        .mem_addr_out(mem_addr_out),
        .crc_en      (crc_en),
        .crc_rdy     (crc_rdy)
    );

    // 50 MHz: rising edges at 10, 30, 50 ... ns
    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        else
            n_pass++;
    endtask

    // Start a scan (start held high afterwards) and follow it cycle by cycle into DONE
    task automatic do_scan(input logic [9:0] a_in, input string tag, input bit perturb);
        int n;
        int addr_err;
        int en_cnt;
        int rdy_bad;
        logic [9:0] exp_addr;
        n        = 1024 - int'(a_in);
        addr_err = 0;
        en_cnt   = 0;
        rdy_bad  = 0;
        @(negedge clk50m);
        mem_addr_in = a_in;
        crc_start   = 1'b1;
        @(negedge clk50m);
        check({tag, " first_addr"}, 32'(mem_addr_out), 32'(a_in));
        check({tag, " en_after_accept"}, 32'(crc_en), 32'd0);
        for (int k = 1; k <= n; k++) begin
            if (perturb && k < n) begin
                crc_start   = k[0];
                mem_addr_in = 10'($urandom);
            end else begin
                crc_start   = 1'b1;
                mem_addr_in = a_in;
            end
            @(negedge clk50m);
            exp_addr = (k < n) ? 10'(int'(a_in) + k) : 10'd1023;
            if (mem_addr_out !== exp_addr) addr_err++;
            if (crc_en === 1'b1) en_cnt++;
            if (crc_rdy !== 1'b0) rdy_bad++;
        end
        check({tag, " addr_seq_errors"}, 32'(addr_err), 32'd0);
        check({tag, " en_cycles"}, 32'(en_cnt), 32'(n));
        check({tag, " rdy_during_scan"}, 32'(rdy_bad), 32'd0);
        @(negedge clk50m);
        check({tag, " en_after_last"}, 32'(crc_en), 32'd0);
        check({tag, " rdy_after_last"}, 32'(crc_rdy), 32'd1);
        check({tag, " final_addr"}, 32'(mem_addr_out), 32'd1023);
    endtask

    // Drop start for one edge and expect return to IDLE
    task automatic drop_start(input string tag);
        crc_start = 1'b0;
        @(negedge clk50m);
        check({tag, " rdy_cleared"}, 32'(crc_rdy), 32'd0);
        check({tag, " en_idle"}, 32'(crc_en), 32'd0);
    endtask

    initial begin
        int bad;
        rst_n       = 1'b0;
        crc_start   = 1'b0;
        mem_addr_in = 10'd0;

        #99;
        check("reset addr", 32'(mem_addr_out), 32'd0);
        check("reset en", 32'(crc_en), 32'd0);
        check("reset rdy", 32'(crc_rdy), 32'd0);
        #1 rst_n = 1'b1;

        // 10 ns pulse strictly between rising edges
        @(posedge clk50m);
        mem_addr_in = 10'd500;
        #5 crc_start = 1'b1;
        #10 crc_start = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk50m);
            if (crc_en !== 1'b0 || crc_rdy !== 1'b0 || mem_addr_out !== 10'd0) bad++;
        end
        check("short pulse ignored", 32'(bad), 32'd0);

        do_scan(10'd0, "full", 1'b0);
        // Start still held: must stay in DONE without rescanning
        bad = 0;
        repeat (8) begin
            @(negedge clk50m);
            if (crc_rdy !== 1'b1 || crc_en !== 1'b0 || mem_addr_out !== 10'd1023) bad++;
        end
        check("done hold", 32'(bad), 32'd0);
        drop_start("full");

        do_scan(10'd1020, "part1020", 1'b0);
        drop_start("part1020");

        do_scan(10'd1023, "one_word", 1'b0);
        drop_start("one_word");

        do_scan(10'd0, "restart_perturbed", 1'b1);
        drop_start("restart_perturbed");

        do_scan(10'd700, "mid700", 1'b1);
        drop_start("mid700");

        // Reset asserted mid-scan takes effect without waiting for an edge
        @(negedge clk50m);
        mem_addr_in = 10'd100;
        crc_start   = 1'b1;
        repeat (10) @(negedge clk50m);
        check("pre-reset en", 32'(crc_en), 32'd1);
        check("pre-reset addr", 32'(mem_addr_out), 32'd109);
        #3 rst_n = 1'b0;
        #1;
        check("midscan reset addr", 32'(mem_addr_out), 32'd0);
        check("midscan reset en", 32'(crc_en), 32'd0);
        check("midscan reset rdy", 32'(crc_rdy), 32'd0);
        crc_start = 1'b0;
        @(negedge clk50m);
        rst_n = 1'b1;
        repeat (3) @(negedge clk50m);
        check("post-reset idle en", 32'(crc_en), 32'd0);
        check("post-reset idle addr", 32'(mem_addr_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crc_fsm.md
# crc_fsm

Control state machine for the CRC generation block. On a start request it walks a 1024-word synchronous-read memory from a given start address up to address 1023. It drives the read address, qualifies each returned data word for the CRC calculator with `crc_en`, and flags completion with `crc_rdy`. It sits between the memory (address side) and the CRC calculation unit (enable side).

## Interface
- No parameters. Address width is fixed at 10 bits; the last address is 1023.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk50m` in 1: system clock, 50 MHz, rising-edge active.
- `rst_n` in 1: asynchronous active-low reset.
- `crc_start` in 1: start request, level, sampled on `clk50m` rising edge.
- `mem_addr_in` in 10: start address of the scan, loaded when a start is accepted.
- `mem_addr_out` out 10: memory read address, registered.
- `crc_en` out 1: registered; high while the memory output holds a word the CRC calculator must consume.
- `crc_rdy` out 1: registered; high when the scan has finished.

## Operation
- States:
  - IDLE: no scan.
  - SCAN: presenting addresses.
  - FLUSH: last data word is on the memory output.
  - DONE: scan complete.
- Internal 10-bit address register `addr` drives `mem_addr_out` directly.
- IDLE:
  - `crc_en`=0, `crc_rdy`=0, `addr` holds.
  - If `crc_start`=1 at an edge: `addr`<=`mem_addr_in`, go to SCAN.
- SCAN, at each edge:
  - `crc_en`<=1, because the data for the current `addr` becomes valid next cycle.
  - If `addr`==1023: `addr` holds, go to FLUSH.
  - Otherwise `addr`<=`addr`+1.
- FLUSH, at the edge: `crc_en`<=0, `crc_rdy`<=1, go to DONE.
- DONE:
  - `crc_rdy`=1, `crc_en`=0, `addr` holds at 1023.
  - If `crc_start`=0 at an edge: `crc_rdy`<=0, go to IDLE.
- `crc_start` is ignored in SCAN and FLUSH.
- A new scan requires `crc_start` to be low for at least one edge after DONE. A start held high continuously therefore runs exactly one scan.
- The address never wraps: increment happens only when `addr`<1023.
- `mem_addr_in`=1023 gives a one-word scan.
- `mem_addr_in` is sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset, asynchronous and immediate: state IDLE, `mem_addr_out`=0, `crc_en`=0, `crc_rdy`=0. Reset asserted mid-scan aborts the scan with the same values.
- Release of `rst_n` is synchronous to the next edge; no start is accepted before the first edge with `rst_n`=1.
- `crc_start` is purely sampled. A pulse that does not span a rising edge of `clk50m` is ignored; for example, a 10 ns pulse between edges is lost.
- Latency, with start accepted at edge E0 and N = 1024 − `mem_addr_in`:
  - `mem_addr_out`=`mem_addr_in` after E0.
  - `mem_addr_out`=`mem_addr_in`+k after E0+k, for k<N.
  - `crc_en` high from after E1 to after E(N), i.e. exactly N cycles, with no gaps.
  - `crc_rdy` rises after E(N+1), the same edge at which `crc_en` falls.
- The memory is assumed to have 1-cycle read latency: data for the address presented in cycle c is valid in cycle c+1, aligned with `crc_en`.
- All outputs are glitch-free registers.

## Test plan
- Reset: hold `rst_n`=0 for 99 ns with `crc_start`=0 -> `mem_addr_out`=0, `crc_en`=0, `crc_rdy`=0; assert `rst_n`=0 mid-SCAN -> the same values immediately.
- Short start pulse: `crc_start` high 10 ns between rising edges -> state remains IDLE, `crc_en` never rises.
- Full scan: `mem_addr_in`=0, `crc_start` held high ->
  - `mem_addr_out` steps 0..1023 one per cycle.
  - `crc_en` high for exactly 1024 cycles.
  - `crc_rdy`=1 one cycle after the last address, about 20.5 µs.
  - `crc_rdy` stays 1 and no second scan starts while `crc_start` is held.
- Partial scan: `mem_addr_in`=1020 -> addresses 1020..1023, `crc_en` high 4 cycles, then `crc_rdy`=1; `mem_addr_in`=1023 -> `crc_en` high 1 cycle.
- Restart: from DONE drop `crc_start` for one edge -> `crc_rdy`=0 (IDLE); raise it again with `mem_addr_in`=0 -> a new full 1024-cycle scan.
- Start ignored mid-scan: toggle `crc_start` and change `mem_addr_in` during SCAN -> address sequence and `crc_en` count unchanged.
